// File: rtl/mul_32_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_32_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_32_seq.sv
// Iterative shift-add multiplier producing a 2*WIDTH product split as Y_hi/Y_lo.
// Defining MUL_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier bits are all zero.
import mul_32_pkg::*;

module mul_32_seq #(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  mul_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]     s_mag, t_mag;
  logic                 last;

  // Two's-complement negation of the most negative value yields 2^(WIDTH-1) as unsigned.
  assign s_mag = (sgn && S[WIDTH-1]) ? -S : S;
  assign t_mag = (sgn && T[WIDTH-1]) ? -T : T;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    y_d     = y_q;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, s_mag};
          mplr_d  = t_mag;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = sgn & (S[WIDTH-1] ^ T[WIDTH-1]);
          state_d = RUN;
        end
      end
      RUN: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
`ifdef MUL_EARLY_EXIT_EN
        last    = (cnt_q == CntW'(WIDTH - 1)) || (mplr_d == '0);
`else
        last    = (cnt_q == CntW'(WIDTH - 1));
`endif
        if (last) begin
          // Result is captured on the edge into FIN so it is valid alongside done.
          y_d     = neg_q ? -acc_d : acc_d;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign Y_hi = y_q[2*WIDTH-1:WIDTH];
  assign Y_lo = y_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_32_seq.sv
// Scoreboard bench for mul_32_seq: driver queues hand-computed products, a monitor checks on done.
module tb_mul_32_seq;

  logic        clk = 1'b0;
  logic        reset, start, sgn;
  logic [31:0] S, T;
  logic        busy, done;
  logic [31:0] Y_hi, Y_lo;

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  logic [63:0] sb_y[$];
  int          sb_at[$];
  logic [63:0] last_y;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  mul_32_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sgn   (sgn),
    .S     (S),
    .T     (T),
    .busy  (busy),
    .done  (done),
    .Y_hi  (Y_hi),
    .Y_lo  (Y_lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Cycle of done after acceptance; cycle 1 is the first cycle after the accepting edge.
  function automatic int exp_lat(input logic sg, input logic [31:0] t);
`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] mag;
    int          hb;
    mag = (sg && t[31]) ? -t : t;
    hb  = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
    return (hb < 0) ? 2 : hb + 2;
`else
    return 33;
`endif
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb_y.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at edge %0d, expected done=0", edge_cnt);
      end else begin
        logic [63:0] e;
        int          at;
        e  = sb_y.pop_front();
        at = sb_at.pop_front();
        chk("product", {Y_hi, Y_lo}, e);
        chk("done_cycle", 64'(edge_cnt), 64'(at));
      end
    end
  end

  // Queue expectation and present a one-cycle start; returns in cycle 1 (+1ns).
  task automatic issue(input logic sg, input logic [31:0] s, input logic [31:0] t,
                       input logic [63:0] exp);
    sb_y.push_back(exp);
    sb_at.push_back(edge_cnt + exp_lat(sg, t));
    sgn = sg; S = s; T = t; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    S = 32'hDEAD_BEEF; T = 32'h0BAD_F00D; sgn = ~sg;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_y.size() != 0 && n < 64) begin
      chk("busy_during_op", 64'(busy), 64'd1);
      @(negedge clk); #1;
      n++;
    end
    if (sb_y.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, expected one done", n);
      sb_y.delete();
      sb_at.delete();
    end else begin
      chk("busy_at_done", 64'(busy), 64'd1);
    end
  endtask

  task automatic run_one(input logic sg, input logic [31:0] s, input logic [31:0] t,
                         input logic [63:0] exp);
    issue(sg, s, t, exp);
    chk("y_held_at_start", {Y_hi, Y_lo}, last_y);
    wait_done();
    last_y = exp;
    @(negedge clk); #1;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_pulse_width", 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; sgn = 1'b0; S = '0; T = '0;
    last_y = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_y", {Y_hi, Y_lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk); #1;

    run_one(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_one(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_one(1'b1, 32'h0000_0005, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1);
    run_one(1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 64'h0000_0004_FFFF_FFF1);
    run_one(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_one(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000);
    run_one(1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000);
    run_one(1'b0, 32'h0000_0010, 32'h0000_0100, 64'h0000_0000_0000_1000);
    run_one(1'b1, 32'h0000_0007, 32'h8000_0000, 64'hFFFF_FFFC_8000_0000);

    // Signed -7*6 with stray starts mid-run and during FIN.
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6);
    repeat (3) begin @(negedge clk); #1; end
    sgn = 1'b0; S = 32'd3; T = 32'd3; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done();
    sgn = 1'b0; S = 32'd3; T = 32'd3; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("start_in_fin_ignored", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    #1;
    chk("y_unchanged_after", {Y_hi, Y_lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    last_y = 64'hFFFF_FFFF_FFFF_FFD6;

    // Reset in cycle 10 of a run aborts it without a done.
    sgn = 1'b0; S = 32'h1234_5678; T = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(negedge clk); #1; end
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_y", {Y_hi, Y_lo}, 64'd0);
    last_y = '0;
    repeat (40) @(negedge clk);
    #1;
    run_one(1'b0, 32'd5, 32'd4, 64'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
